multdiv_sequencer: RTL and testbench

MULTDIV_SEQUENCER -- requirements
Module: multdiv_sequencer

---
 rtl/multdiv_pkg.sv | 25 ++
 rtl/md_timeout_counter.sv | 26 ++
 rtl/multdiv_sequencer.sv | 120 ++++++++++++
 tb/tb_multdiv_sequencer.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/multdiv_pkg.sv
// Shared definitions for the multiply/divide sequencer: FSM states,
// ALU op codes of the two R-type instructions and the rstatus exception codes.
package multdiv_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } md_state_t;

    localparam logic [4:0]  ALU_OP_MUL  = 5'b00110;
    localparam logic [4:0]  ALU_OP_DIV  = 5'b00111;

    localparam logic [31:0] RSTATUS_MUL = 32'd4;
    localparam logic [31:0] RSTATUS_DIV = 32'd5;

    // Exception code written to r30; zero when the op completed cleanly.
    function automatic logic [31:0] rstatus_code(input logic is_div, input logic exc);
        if (!exc)
            return 32'd0;
        return is_div ? RSTATUS_DIV : RSTATUS_MUL;
    endfunction

endpackage

// File: rtl/md_timeout_counter.sv
// Counts WAIT cycles and flags the last one allowed before a forced abort.
module md_timeout_counter #(
    parameter int TIMEOUT = 48,
    parameter int CW      = 6
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic inc,
    output logic terminal
);

    logic [CW-1:0] count;

    always_ff @(posedge clock) begin
        if (reset || clear)
            count <= '0;
        else if (inc)
            count <= count + CW'(1);
    end

    // count holds the number of WAIT cycles already completed, so the
    // TIMEOUT-th WAIT cycle is the one where count == TIMEOUT-1.
    assign terminal = inc && (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/multdiv_sequencer.sv
// Sequences one mul/div through the multi-cycle multdiv unit, stalling the
// front of the pipeline until a result (or a timeout abort) is available.
import multdiv_pkg::*;

module multdiv_sequencer #(
    parameter int TIMEOUT = 48,
    parameter int CW      = 6
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_mult,
    input  logic        req_div,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic [4:0]  req_rd,
    input  logic [31:0] md_result,
    input  logic        md_exception,
    input  logic        md_ready,
    output logic        ctrl_mult,
    output logic        ctrl_div,
    output logic [31:0] md_a,
    output logic [31:0] md_b,
    output logic        stall,
    output logic        result_valid,
    output logic [31:0] result,
    output logic [31:0] rstatus_val,
    output logic        exception,
    output logic [4:0]  result_rd,
    output logic        busy
);

    md_state_t   state, state_next;
    logic [4:0]  op_q;
    logic [4:0]  rd_q;
    logic        is_div;
    logic        accept;
    logic        finish;
    logic        timeout_tc;
    logic        exc_next;

    md_timeout_counter #(
        .TIMEOUT (TIMEOUT),
        .CW      (CW)
    ) u_timeout (
        .clock    (clock),
        .reset    (reset),
        .clear    (state != S_WAIT),
        .inc      (state == S_WAIT),
        .terminal (timeout_tc)
    );

    assign is_div = (op_q == ALU_OP_DIV);

    always_ff @(posedge clock) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    // md_ready only matters in WAIT; requests only matter in IDLE.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        finish     = 1'b0;
        case (state)
            S_IDLE: begin
                if (req_mult || req_div) begin
                    accept     = 1'b1;
                    state_next = S_START;
                end
            end
            S_START: state_next = S_WAIT;
            S_WAIT: begin
                if (md_ready || timeout_tc) begin
                    finish     = 1'b1;
                    state_next = S_DONE;
                end
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // A real ready wins over a coincident timeout on the last WAIT cycle.
    assign exc_next = md_ready ? md_exception : 1'b1;

    always_ff @(posedge clock) begin
        if (reset) begin
            op_q        <= ALU_OP_MUL;
            rd_q        <= '0;
            md_a        <= '0;
            md_b        <= '0;
            result      <= '0;
            rstatus_val <= '0;
            exception   <= 1'b0;
            result_rd   <= '0;
        end else begin
            if (accept) begin
                op_q <= req_mult ? ALU_OP_MUL : ALU_OP_DIV;
                rd_q <= req_rd;
                md_a <= op_a;
                md_b <= op_b;
            end
            if (finish) begin
                result      <= md_ready ? md_result : 32'd0;
                exception   <= exc_next;
                rstatus_val <= rstatus_code(is_div, exc_next);
                result_rd   <= rd_q;
            end
        end
    end

    assign ctrl_mult    = (state == S_START) && !is_div;
    assign ctrl_div     = (state == S_START) &&  is_div;
    assign stall        = accept || (state == S_START) || (state == S_WAIT);
    assign result_valid = (state == S_DONE);
    assign busy         = (state != S_IDLE);

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Randomized self-checking bench: each op is predicted at transaction level
// (latency from ready delay / timeout, result from signed arithmetic).
module tb_multdiv_sequencer;

    localparam int TIMEOUT = 48;
    localparam int CW      = 6;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_mult, req_div;
    logic [31:0] op_a, op_b;
    logic [4:0]  req_rd;
    logic [31:0] md_result;
    logic        md_exception, md_ready;
    logic        ctrl_mult, ctrl_div;
    logic [31:0] md_a, md_b;
    logic        stall, result_valid;
    logic [31:0] result, rstatus_val;
    logic        exception;
    logic [4:0]  result_rd;
    logic        busy;

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] exp_res, exp_rst;
    logic        exp_exc;
    logic [4:0]  exp_rd;

    always #5 clock = ~clock;

    multdiv_sequencer #(.TIMEOUT(TIMEOUT), .CW(CW)) dut (
        .clock(clock), .reset(reset), .req_mult(req_mult), .req_div(req_div),
        .op_a(op_a), .op_b(op_b), .req_rd(req_rd), .md_result(md_result),
        .md_exception(md_exception), .md_ready(md_ready), .ctrl_mult(ctrl_mult),
        .ctrl_div(ctrl_div), .md_a(md_a), .md_b(md_b), .stall(stall),
        .result_valid(result_valid), .result(result), .rstatus_val(rstatus_val),
        .exception(exception), .result_rd(result_rd), .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    // Behaviour of an ideal multdiv unit, used to feed md_result/md_exception.
    function automatic void md_model(input bit is_div, input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] res, output bit exc);
        longint p;
        if (!is_div) begin
            p   = longint'($signed(a)) * longint'($signed(b));
            res = p[31:0];
            exc = (p > 64'sd2147483647) || (p < -64'sd2147483648);
        end else if (b == 32'd0) begin
            res = 32'd0;
            exc = 1'b1;
        end else begin
            res = $signed(a) / $signed(b);
            exc = 1'b0;
        end
    endfunction

    // Drives one instruction from its IDLE acceptance through DONE.
    // rdelay = WAIT cycle (1-based) in which md_ready rises; outside 1..TIMEOUT means never.
    task automatic run_op(input bit mul, input bit div, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input int rdelay, input bit start_glitch);
        bit          is_div, mexc, tmo;
        logic [31:0] mres;
        int          w;
        is_div = !mul;
        md_model(is_div, a, b, mres, mexc);
        tmo = (rdelay < 1) || (rdelay > TIMEOUT);
        w   = tmo ? TIMEOUT : rdelay;
        req_mult = mul; req_div = div; op_a = a; op_b = b; req_rd = rd; md_ready = 1'b0;

        @(negedge clock);
        chk("acc_stall", 32'(stall), 32'd1);
        chk("acc_busy",  32'(busy),  32'd0);
        chk("acc_ctrl",  32'({ctrl_mult, ctrl_div}), 32'd0);

        @(posedge clock); #1;
        md_ready = start_glitch; md_result = 32'hdead_beef; md_exception = 1'b1;
        @(negedge clock);
        chk("start_ctrl_mult", 32'(ctrl_mult), 32'(!is_div));
        chk("start_ctrl_div",  32'(ctrl_div),  32'(is_div));
        chk("start_stall", 32'(stall), 32'd1);
        chk("start_md_a", md_a, a);
        chk("start_md_b", md_b, b);

        for (int k = 1; k <= w; k++) begin
            @(posedge clock); #1;
            md_ready     = (!tmo && k == rdelay);
            md_result    = md_ready ? mres : $urandom;
            md_exception = md_ready ? mexc : 1'b1;
            @(negedge clock);
            chk("wait_stall", 32'(stall), 32'd1);
            chk("wait_rv",    32'(result_valid), 32'd0);
            chk("wait_ctrl",  32'({ctrl_mult, ctrl_div}), 32'd0);
            chk("wait_md_a",  md_a, a);
        end

        @(posedge clock); #1;
        md_ready = 1'b0;
        exp_exc = tmo ? 1'b1 : mexc;
        exp_res = tmo ? 32'd0 : mres;
        exp_rst = !exp_exc ? 32'd0 : (is_div ? 32'd5 : 32'd4);
        exp_rd  = rd;
        @(negedge clock);
        chk("done_rv",     32'(result_valid), 32'd1);
        chk("done_stall",  32'(stall), 32'd0);
        chk("done_busy",   32'(busy),  32'd1);
        chk("done_result", result, exp_res);
        chk("done_exc",    32'(exception), 32'(exp_exc));
        chk("done_rstatus", rstatus_val, exp_rst);
        chk("done_rd",     32'(result_rd), 32'(exp_rd));
        chk("done_ctrl",   32'({ctrl_mult, ctrl_div}), 32'd0);
        @(posedge clock); #1;
    endtask

    // One IDLE cycle with no request: outputs must hold and md_ready is ignored.
    task automatic idle_check();
        req_mult = 1'b0; req_div = 1'b0;
        md_ready = 1'($urandom_range(0, 1)); md_exception = 1'b1; md_result = $urandom;
        @(negedge clock);
        chk("idle_stall", 32'(stall), 32'd0);
        chk("idle_busy",  32'(busy),  32'd0);
        chk("idle_rv",    32'(result_valid), 32'd0);
        chk("hold_result", result, exp_res);
        chk("hold_exc",    32'(exception), 32'(exp_exc));
        chk("hold_rstatus", rstatus_val, exp_rst);
        chk("hold_rd",     32'(result_rd), 32'(exp_rd));
        @(posedge clock); #1;
        md_ready = 1'b0;
    endtask

    task automatic reset_outputs_check(input string tag);
        chk({tag, "_busy"},   32'(busy), 32'd0);
        chk({tag, "_stall"},  32'(stall), 32'd0);
        chk({tag, "_rv"},     32'(result_valid), 32'd0);
        chk({tag, "_ctrl"},   32'({ctrl_mult, ctrl_div}), 32'd0);
        chk({tag, "_md_a"},   md_a, 32'd0);
        chk({tag, "_md_b"},   md_b, 32'd0);
        chk({tag, "_result"}, result, 32'd0);
        chk({tag, "_rstatus"}, rstatus_val, 32'd0);
        chk({tag, "_exc"},    32'(exception), 32'd0);
        chk({tag, "_rd"},     32'(result_rd), 32'd0);
    endtask

    initial begin
        reset = 1'b1; req_mult = 1'b0; req_div = 1'b0; op_a = '0; op_b = '0; req_rd = '0;
        md_result = '0; md_exception = 1'b0; md_ready = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        @(negedge clock);
        reset_outputs_check("reset");
        @(posedge clock); #1;
        reset = 1'b0;
        exp_res = '0; exp_rst = '0; exp_exc = 1'b0; exp_rd = '0;

        // Directed: mul 7*-3 with ready in WAIT cycle 32.
        run_op(1'b1, 1'b0, 32'd7, -32'sd3, 5'd5, 32, 1'b0);
        idle_check();
        // Divide by zero.
        run_op(1'b0, 1'b1, 32'd10, 32'd0, 5'd9, 5, 1'b0);
        idle_check();
        // Timeout on a mult, ready on the very last WAIT cycle, minimum latency.
        run_op(1'b1, 1'b0, 32'd3, 32'd4, 5'd12, 0, 1'b0);
        idle_check();
        run_op(1'b1, 1'b0, 32'd100, 32'd200, 5'd13, TIMEOUT, 1'b0);
        idle_check();
        run_op(1'b0, 1'b1, 32'd99, 32'd7, 5'd14, 1, 1'b0);
        idle_check();
        // Collision (mult wins, START ready ignored), then div back-to-back.
        run_op(1'b1, 1'b1, 32'd6, 32'd7, 5'd20, 4, 1'b1);
        run_op(1'b0, 1'b1, -32'sd50, 32'd7, 5'd21, 6, 1'b0);
        idle_check();

        // Reset in WAIT cycle 10, late ready 3 cycles after reset.
        req_mult = 1'b1; req_div = 1'b0; op_a = 32'd11; op_b = 32'd13; req_rd = 5'd7;
        @(posedge clock); #1;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clock); #1;
        end
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0; req_mult = 1'b0;
        @(negedge clock);
        reset_outputs_check("midrst");
        for (int j = 1; j <= 8; j++) begin
            @(posedge clock); #1;
            md_ready = (j == 2); md_result = 32'd143; md_exception = 1'b0;
            @(negedge clock);
            chk("midrst_no_rv",  32'(result_valid), 32'd0);
            chk("midrst_idle",   32'(busy), 32'd0);
            chk("midrst_result", result, 32'd0);
        end
        @(posedge clock); #1;
        md_ready = 1'b0;
        exp_res = '0; exp_rst = '0; exp_exc = 1'b0; exp_rd = '0;
        idle_check();

        // Randomized ops, sometimes back-to-back, sometimes with collisions.
        for (int i = 0; i < 24; i++) begin
            bit          m, d, glitch;
            logic [31:0] a, b;
            int          rdl;
            m = 1'($urandom_range(0, 1));
            d = m ? 1'($urandom_range(0, 1)) : 1'b1;
            a = $urandom;
            b = ($urandom_range(0, 5) == 0) ? 32'd0 : (($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(1, 1000)));
            if (a == 32'h8000_0000) a = 32'd1;
            rdl = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, TIMEOUT + 2);
            glitch = 1'($urandom_range(0, 1));
            run_op(m, d, a, b, 5'($urandom), rdl, glitch);
            if ($urandom_range(0, 1) != 0)
                idle_check();
        end
        idle_check();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
